// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported RAM between fetch (0), data (1)
// and debug loader (2); one transaction in flight, fixed read latency.
module mem_port_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              req2_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic              we2_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [ADDR_W-1:0] addr2_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic [DATA_W-1:0] wdata2_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic              ack2_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i,
  output logic [1:0]        grant_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] CNT_LAST = 3'(RD_LATENCY - 1);

  state_t            state;
  logic [1:0]        last;
  logic [2:0]        cnt;
  logic [2:0]        ack;
  logic [2:0]        req;
  logic              any_req;
  logic [1:0]        winner;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  assign req     = {req2_i, req1_i, req0_i};
  assign any_req = |req;

  // Search starts at the port after the last one served.
  always_comb begin
    winner = 2'd0;
    case (last)
      2'd0: begin
        if (req[1])      winner = 2'd1;
        else if (req[2]) winner = 2'd2;
        else             winner = 2'd0;
      end
      2'd1: begin
        if (req[2])      winner = 2'd2;
        else if (req[0]) winner = 2'd0;
        else             winner = 2'd1;
      end
      default: begin
        if (req[0])      winner = 2'd0;
        else if (req[1]) winner = 2'd1;
        else             winner = 2'd2;
      end
    endcase
  end

  always_comb begin
    sel_addr  = addr0_i;
    sel_wdata = wdata0_i;
    sel_we    = we0_i;
    case (winner)
      2'd1: begin
        sel_addr  = addr1_i;
        sel_wdata = wdata1_i;
        sel_we    = we1_i;
      end
      2'd2: begin
        sel_addr  = addr2_i;
        sel_wdata = wdata2_i;
        sel_we    = we2_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 2'd2;
      cnt     <= 3'd0;
      ack     <= 3'b000;
      grant_o <= 2'd3;
      addr_o  <= '0;
      data_o  <= '0;
      we_o    <= 1'b0;
      rdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 3'b000;
          if (any_req) begin
            grant_o <= winner;
            addr_o  <= sel_addr;
            data_o  <= sel_wdata;
            we_o    <= sel_we;
            cnt     <= 3'd0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // The registered we_o remembers whether this is a write.
          if (we_o) begin
            we_o  <= 1'b0;
            ack   <= 3'b001 << grant_o;
            state <= RESP;
          end else if (cnt == CNT_LAST) begin
            rdata_o <= data_i;
            ack     <= 3'b001 << grant_o;
            state   <= RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: begin
          ack     <= 3'b000;
          addr_o  <= '0;
          data_o  <= '0;
          last    <= grant_o;
          grant_o <= 2'd3;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ack0_o = ack[0];
  assign ack1_o = ack[1];
  assign ack2_o = ack[2];
  assign busy_o = (state != IDLE);

endmodule
